pcie_req_arbiter: RTL and testbench

- Shares the single PCIe request channel (req_valid/req_ready/type/addr/data/tag) between NUM_REQ requesters using round-robin arbitration.
- Allocates PCIe tags for MRd requests and tracks them in an owner table.
- Routes each returning Completion back to the requester that issued the MRd.
- Sits between the requester agents and the endpoint request/completion interface.

---
 rtl/pcie_req_arbiter_if.sv | 44 ++++
 rtl/pcie_req_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_pcie_req_arbiter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/pcie_req_arbiter_if.sv
// Request/completion bundle around pcie_req_arbiter.
// master is the arbiter's view; slave is the requester/endpoint side.
interface pcie_req_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TYPE_W  = 2
);
   logic [NUM_REQ-1:0]        s_valid;
   logic [NUM_REQ-1:0]        s_ready;
   logic [NUM_REQ*TYPE_W-1:0] s_type;
   logic [NUM_REQ*ADDR_W-1:0] s_addr;
   logic [NUM_REQ*DATA_W-1:0] s_data;
   logic                      req_valid;
   logic                      req_ready;
   logic [TYPE_W-1:0]         req_type;
   logic [ADDR_W-1:0]         req_addr;
   logic [DATA_W-1:0]         req_data;
   logic [7:0]                req_tag;
   logic                      cpl_valid;
   logic [2:0]                cpl_status;
   logic [7:0]                cpl_tag;
   logic [DATA_W-1:0]         cpl_data;
   logic [NUM_REQ-1:0]        r_valid;
   logic [2:0]                r_status;
   logic [DATA_W-1:0]         r_data;
   logic [7:0]                r_tag;
   logic [8:0]                outstanding;
   logic                      err_unexp_cpl;

   modport master (
      input  s_valid, s_type, s_addr, s_data, req_ready,
             cpl_valid, cpl_status, cpl_tag, cpl_data,
      output s_ready, req_valid, req_type, req_addr, req_data, req_tag,
             r_valid, r_status, r_data, r_tag, outstanding, err_unexp_cpl
   );

   modport slave (
      output s_valid, s_type, s_addr, s_data, req_ready,
             cpl_valid, cpl_status, cpl_tag, cpl_data,
      input  s_ready, req_valid, req_type, req_addr, req_data, req_tag,
             r_valid, r_status, r_data, r_tag, outstanding, err_unexp_cpl
   );
endinterface

// File: rtl/pcie_req_arbiter.sv
// Round-robin arbiter sharing one PCIe request channel among NUM_REQ requesters,
// with MRd tag allocation and completion routing back to the issuing requester.
module pcie_req_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int TYPE_W   = 2,
   parameter int MAX_OUTS = 8
) (
   input logic                clk,
   input logic                rst,
   pcie_req_arbiter_if.master bus
);
   localparam int IDX_W = $clog2(NUM_REQ);
   localparam logic [TYPE_W-1:0] TLP_MRd = TYPE_W'(0);

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    rr_ptr, grant_q, grant_d, cpl_owner;
   logic                gnt_found, hs, any_free, cpl_hit, alloc;
   logic [7:0]          free_tag;
   logic [NUM_REQ-1:0]  elig, s_ready_c, r_valid_d;
   logic [IDX_W:0]      scan_idx;
   logic [TYPE_W-1:0]   sel_type;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_data;
   logic [MAX_OUTS-1:0] busy, busy_d;
   logic [IDX_W-1:0]    owner [MAX_OUTS];
   logic [8:0]          outstanding_q;
   logic                req_mrd_q;
   logic [TYPE_W-1:0]   req_type_q;
   logic [ADDR_W-1:0]   req_addr_q;
   logic [DATA_W-1:0]   req_data_q;
   logic [7:0]          req_tag_q;
   logic [NUM_REQ-1:0]  r_valid_q;
   logic [2:0]          r_status_q;
   logic [DATA_W-1:0]   r_data_q;
   logic [7:0]          r_tag_q;
   logic                err_q;

   // Lowest free tag from the registered (pre-edge) busy map
   always_comb begin
      any_free = 1'b0;
      free_tag = 8'd0;
      for (int t = MAX_OUTS - 1; t >= 0; t--) begin
         if (!busy[t]) begin
            any_free = 1'b1;
            free_tag = 8'(t);
         end
      end
   end

   always_comb begin
      elig = '0;
      for (int i = 0; i < NUM_REQ; i++)
         elig[i] = bus.s_valid[i] &&
                   ((bus.s_type[i*TYPE_W +: TYPE_W] != TLP_MRd) || any_free);
      gnt_found = 1'b0;
      grant_d   = rr_ptr;
      scan_idx  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_idx = {1'b0, rr_ptr} + (IDX_W+1)'(k);
         if (scan_idx >= (IDX_W+1)'(NUM_REQ))
            scan_idx = scan_idx - (IDX_W+1)'(NUM_REQ);
         for (int j = 0; j < NUM_REQ; j++) begin
            if (!gnt_found && elig[j] && scan_idx == (IDX_W+1)'(j)) begin
               gnt_found = 1'b1;
               grant_d   = IDX_W'(j);
            end
         end
      end
      sel_type = '0;
      sel_addr = '0;
      sel_data = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (grant_d == IDX_W'(j)) begin
            sel_type = bus.s_type[j*TYPE_W +: TYPE_W];
            sel_addr = bus.s_addr[j*ADDR_W +: ADDR_W];
            sel_data = bus.s_data[j*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      hs        = 1'b0;
      s_ready_c = '0;
      case (state_q)
         IDLE: if (gnt_found) state_d = ISSUE;
         ISSUE: begin
            if (bus.req_ready) begin
               hs      = 1'b1;
               state_d = IDLE;
               for (int j = 0; j < NUM_REQ; j++)
                  s_ready_c[j] = (grant_q == IDX_W'(j));
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A completion may free one tag while the handshake claims another on the same edge
   always_comb begin
      alloc     = hs && req_mrd_q;
      cpl_hit   = 1'b0;
      cpl_owner = '0;
      busy_d    = busy;
      for (int t = 0; t < MAX_OUTS; t++) begin
         if (bus.cpl_valid && bus.cpl_tag == 8'(t) && busy[t]) begin
            cpl_hit   = 1'b1;
            cpl_owner = owner[t];
            busy_d[t] = 1'b0;
         end
         if (alloc && req_tag_q == 8'(t)) busy_d[t] = 1'b1;
      end
      r_valid_d = '0;
      for (int j = 0; j < NUM_REQ; j++)
         r_valid_d[j] = cpl_hit && (cpl_owner == IDX_W'(j));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         rr_ptr        <= '0;
         grant_q       <= '0;
         busy          <= '0;
         outstanding_q <= 9'd0;
         req_mrd_q     <= 1'b0;
         req_type_q    <= '0;
         req_addr_q    <= '0;
         req_data_q    <= '0;
         req_tag_q     <= 8'd0;
         r_valid_q     <= '0;
         r_status_q    <= 3'd0;
         r_data_q      <= '0;
         r_tag_q       <= 8'd0;
         err_q         <= 1'b0;
      end else begin
         state_q <= state_d;
         busy    <= busy_d;
         if (state_q == IDLE && gnt_found) begin
            grant_q    <= grant_d;
            req_type_q <= sel_type;
            req_addr_q <= sel_addr;
            req_data_q <= sel_data;
            req_mrd_q  <= (sel_type == TLP_MRd);
            req_tag_q  <= (sel_type == TLP_MRd) ? free_tag : 8'd0;
         end
         if (hs)
            rr_ptr <= (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
         case ({alloc, cpl_hit})
            2'b10:   outstanding_q <= outstanding_q + 9'd1;
            2'b01:   outstanding_q <= outstanding_q - 9'd1;
            default: outstanding_q <= outstanding_q;
         endcase
         r_valid_q <= r_valid_d;
         err_q     <= bus.cpl_valid && !cpl_hit;
         if (bus.cpl_valid) begin
            r_status_q <= bus.cpl_status;
            r_data_q   <= bus.cpl_data;
            r_tag_q    <= bus.cpl_tag;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int t = 0; t < MAX_OUTS; t++)
         if (alloc && req_tag_q == 8'(t)) owner[t] <= grant_q;
   end

   assign bus.s_ready       = s_ready_c;
   assign bus.req_valid     = (state_q == ISSUE);
   assign bus.req_type      = req_type_q;
   assign bus.req_addr      = req_addr_q;
   assign bus.req_data      = req_data_q;
   assign bus.req_tag       = req_tag_q;
   assign bus.r_valid       = r_valid_q;
   assign bus.r_status      = r_status_q;
   assign bus.r_data        = r_data_q;
   assign bus.r_tag         = r_tag_q;
   assign bus.outstanding   = outstanding_q;
   assign bus.err_unexp_cpl = err_q;
endmodule

// File: tb/tb_pcie_req_arbiter.sv
// Directed bench for pcie_req_arbiter: one DUT with 8 tags, one with 2 tags.
module tb_pcie_req_arbiter;
   localparam logic [1:0] MRD = 2'd0;
   localparam logic [1:0] MWR = 2'd1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   fails  = 0;

   always #5 clk = ~clk;

   pcie_req_arbiter_if #(.NUM_REQ(4), .ADDR_W(32), .DATA_W(32), .TYPE_W(2)) ifa ();
   pcie_req_arbiter_if #(.NUM_REQ(4), .ADDR_W(32), .DATA_W(32), .TYPE_W(2)) ifb ();

   pcie_req_arbiter #(.NUM_REQ(4), .ADDR_W(32), .DATA_W(32), .TYPE_W(2), .MAX_OUTS(8))
      dut_a (.clk(clk), .rst(rst), .bus(ifa.master));
   pcie_req_arbiter #(.NUM_REQ(4), .ADDR_W(32), .DATA_W(32), .TYPE_W(2), .MAX_OUTS(2))
      dut_b (.clk(clk), .rst(rst), .bus(ifb.master));

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs;
      ifa.s_valid = '0; ifa.s_type = '0; ifa.s_addr = '0; ifa.s_data = '0;
      ifa.req_ready = 1'b0; ifa.cpl_valid = 1'b0; ifa.cpl_status = '0;
      ifa.cpl_tag = '0; ifa.cpl_data = '0;
      ifb.s_valid = '0; ifb.s_type = '0; ifb.s_addr = '0; ifb.s_data = '0;
      ifb.req_ready = 1'b0; ifb.cpl_valid = 1'b0; ifb.cpl_status = '0;
      ifb.cpl_tag = '0; ifb.cpl_data = '0;
   endtask

   task automatic do_reset;
      clear_inputs();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset;
      do_reset();
      checks++; if (ifa.req_valid !== 1'b0) begin $display("FAIL reset_req_valid: got %b want 0", ifa.req_valid); fails++; end
      checks++; if (ifa.outstanding !== 9'd0) begin $display("FAIL reset_outstanding: got %0d want 0", ifa.outstanding); fails++; end
      checks++; if (ifa.r_valid !== 4'b0) begin $display("FAIL reset_r_valid: got %b want 0000", ifa.r_valid); fails++; end
      checks++; if (ifa.err_unexp_cpl !== 1'b0) begin $display("FAIL reset_err: got %b want 0", ifa.err_unexp_cpl); fails++; end
      checks++; if (ifa.req_tag !== 8'd0 || ifa.req_addr !== 32'd0) begin $display("FAIL reset_req_payload: tag %h addr %h want 0", ifa.req_tag, ifa.req_addr); fails++; end
      checks++; if (ifa.s_ready !== 4'b0) begin $display("FAIL reset_s_ready: got %b want 0000", ifa.s_ready); fails++; end
   endtask

   task automatic test_wait_states;
      do_reset();
      ifa.s_valid[0] = 1'b1; ifa.s_type[1:0] = MRD; ifa.s_addr[31:0] = 32'h100;
      #1;
      checks++; if (ifa.req_valid !== 1'b0) begin $display("FAIL ws_idle_valid: got %b want 0", ifa.req_valid); fails++; end
      for (int k = 0; k < 4; k++) begin
         step();
         if (k == 3) ifa.req_ready = 1'b1;
         #1;
         checks++; if (ifa.req_valid !== 1'b1 || ifa.req_tag !== 8'd0 || ifa.req_addr !== 32'h100)
            begin $display("FAIL ws_hold_c%0d: valid %b tag %h addr %h want 1/00/100", k, ifa.req_valid, ifa.req_tag, ifa.req_addr); fails++; end
         checks++; if (ifa.s_ready !== ((k == 3) ? 4'b0001 : 4'b0000))
            begin $display("FAIL ws_s_ready_c%0d: got %b want %b", k, ifa.s_ready, (k == 3) ? 4'b0001 : 4'b0000); fails++; end
      end
      step();
      ifa.s_valid = '0; ifa.req_ready = 1'b0;
      checks++; if (ifa.req_valid !== 1'b0 || ifa.outstanding !== 9'd1)
         begin $display("FAIL ws_after: valid %b outstanding %0d want 0/1", ifa.req_valid, ifa.outstanding); fails++; end
   endtask

   task automatic test_round_robin;
      logic [3:0] exp_rdy;
      int gi;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         ifa.s_type[2*i +: 2] = MWR;
         ifa.s_addr[32*i +: 32] = 32'h1000 + 32'(i);
      end
      ifa.s_valid = 4'b1111; ifa.req_ready = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         step();
         gi = ((c - 1) / 2) % 4;
         exp_rdy = (c % 2 == 1) ? (4'b0001 << gi) : 4'b0000;
         checks++; if (ifa.s_ready !== exp_rdy) begin $display("FAIL rr_s_ready_c%0d: got %b want %b", c, ifa.s_ready, exp_rdy); fails++; end
         if (c % 2 == 1) begin
            checks++; if (ifa.req_addr !== 32'h1000 + 32'(gi) || ifa.req_tag !== 8'd0 || ifa.req_type !== MWR)
               begin $display("FAIL rr_payload_c%0d: addr %h tag %h type %0d want %h/00/1", c, ifa.req_addr, ifa.req_tag, ifa.req_type, 32'h1000 + 32'(gi)); fails++; end
         end
      end
      ifa.s_valid = '0; ifa.req_ready = 1'b0;
      step();
   endtask

   task automatic test_tag_exhaust;
      do_reset();
      ifb.s_valid[1] = 1'b1; ifb.s_type[3:2] = MRD; ifb.s_addr[63:32] = 32'h200; ifb.req_ready = 1'b1;
      step();
      checks++; if (ifb.s_ready !== 4'b0010 || ifb.req_tag !== 8'd0) begin $display("FAIL ex_first: rdy %b tag %h want 0010/00", ifb.s_ready, ifb.req_tag); fails++; end
      step();
      checks++; if (ifb.outstanding !== 9'd1) begin $display("FAIL ex_out1: got %0d want 1", ifb.outstanding); fails++; end
      step();
      checks++; if (ifb.s_ready !== 4'b0010 || ifb.req_tag !== 8'd1) begin $display("FAIL ex_second: rdy %b tag %h want 0010/01", ifb.s_ready, ifb.req_tag); fails++; end
      step();
      ifb.s_valid[2] = 1'b1; ifb.s_type[5:4] = MWR; ifb.s_addr[95:64] = 32'h220;
      checks++; if (ifb.outstanding !== 9'd2 || ifb.req_valid !== 1'b0) begin $display("FAIL ex_full: out %0d valid %b want 2/0", ifb.outstanding, ifb.req_valid); fails++; end
      step();
      checks++; if (ifb.s_ready !== 4'b0100 || ifb.req_type !== MWR || ifb.req_tag !== 8'd0 || ifb.req_addr !== 32'h220)
         begin $display("FAIL ex_mwr_pass: rdy %b type %0d tag %h addr %h want 0100/1/00/220", ifb.s_ready, ifb.req_type, ifb.req_tag, ifb.req_addr); fails++; end
      step();
      ifb.s_valid[2] = 1'b0;
      checks++; if (ifb.req_valid !== 1'b0) begin $display("FAIL ex_stall1: valid %b want 0", ifb.req_valid); fails++; end
      step();
      checks++; if (ifb.req_valid !== 1'b0 || ifb.outstanding !== 9'd2) begin $display("FAIL ex_stall2: valid %b out %0d want 0/2", ifb.req_valid, ifb.outstanding); fails++; end
      ifb.cpl_valid = 1'b1; ifb.cpl_tag = 8'd0; ifb.cpl_data = 32'h55; ifb.cpl_status = 3'd0;
      step();
      ifb.cpl_valid = 1'b0;
      checks++; if (ifb.r_valid !== 4'b0010 || ifb.outstanding !== 9'd1) begin $display("FAIL ex_cpl: r_valid %b out %0d want 0010/1", ifb.r_valid, ifb.outstanding); fails++; end
      step();
      checks++; if (ifb.s_ready !== 4'b0010 || ifb.req_tag !== 8'd0 || ifb.req_type !== MRD)
         begin $display("FAIL ex_third: rdy %b tag %h type %0d want 0010/00/0", ifb.s_ready, ifb.req_tag, ifb.req_type); fails++; end
      ifb.s_valid = '0;
      step();
   endtask

   task automatic test_cpl_route;
      do_reset();
      ifa.s_valid[3] = 1'b1; ifa.s_type[7:6] = MRD; ifa.s_addr[127:96] = 32'h300; ifa.req_ready = 1'b1;
      step();
      checks++; if (ifa.s_ready !== 4'b1000 || ifa.req_tag !== 8'd0 || ifa.req_addr !== 32'h300)
         begin $display("FAIL cr_issue: rdy %b tag %h addr %h want 1000/00/300", ifa.s_ready, ifa.req_tag, ifa.req_addr); fails++; end
      step();
      ifa.s_valid = '0;
      checks++; if (ifa.outstanding !== 9'd1) begin $display("FAIL cr_out1: got %0d want 1", ifa.outstanding); fails++; end
      ifa.cpl_valid = 1'b1; ifa.cpl_tag = 8'd0; ifa.cpl_data = 32'hDEADBEEF; ifa.cpl_status = 3'd0;
      step();
      ifa.cpl_valid = 1'b0;
      checks++; if (ifa.r_valid !== 4'b1000) begin $display("FAIL cr_r_valid: got %b want 1000", ifa.r_valid); fails++; end
      checks++; if (ifa.r_data !== 32'hDEADBEEF || ifa.r_tag !== 8'd0 || ifa.r_status !== 3'd0)
         begin $display("FAIL cr_r_payload: data %h tag %h st %0d want deadbeef/00/0", ifa.r_data, ifa.r_tag, ifa.r_status); fails++; end
      checks++; if (ifa.outstanding !== 9'd0 || ifa.err_unexp_cpl !== 1'b0)
         begin $display("FAIL cr_out0: out %0d err %b want 0/0", ifa.outstanding, ifa.err_unexp_cpl); fails++; end
      step();
      checks++; if (ifa.r_valid !== 4'b0000) begin $display("FAIL cr_pulse: got %b want 0000", ifa.r_valid); fails++; end
   endtask

   task automatic test_unexpected_and_reset;
      ifa.cpl_valid = 1'b1; ifa.cpl_tag = 8'd5;
      ifb.cpl_valid = 1'b1; ifb.cpl_tag = 8'd2;
      step();
      ifa.cpl_valid = 1'b0; ifb.cpl_valid = 1'b0;
      checks++; if (ifa.err_unexp_cpl !== 1'b1 || ifa.r_valid !== 4'b0) begin $display("FAIL ux_err: err %b r_valid %b want 1/0000", ifa.err_unexp_cpl, ifa.r_valid); fails++; end
      checks++; if (ifb.err_unexp_cpl !== 1'b1 || ifb.r_valid !== 4'b0) begin $display("FAIL ux_range: err %b r_valid %b want 1/0000", ifb.err_unexp_cpl, ifb.r_valid); fails++; end
      step();
      checks++; if (ifa.err_unexp_cpl !== 1'b0) begin $display("FAIL ux_pulse: err %b want 0", ifa.err_unexp_cpl); fails++; end
      ifa.s_valid[0] = 1'b1; ifa.s_type[1:0] = MRD; ifa.s_addr[31:0] = 32'h400; ifa.req_ready = 1'b1;
      step();
      checks++; if (ifa.req_tag !== 8'd0 || ifa.s_ready !== 4'b0001) begin $display("FAIL ux_tag0: tag %h rdy %b want 00/0001", ifa.req_tag, ifa.s_ready); fails++; end
      step();
      step();
      checks++; if (ifa.req_tag !== 8'd1 || ifa.s_ready !== 4'b0001) begin $display("FAIL ux_tag1: tag %h rdy %b want 01/0001", ifa.req_tag, ifa.s_ready); fails++; end
      step();
      ifa.s_valid = '0; ifa.req_ready = 1'b0;
      checks++; if (ifa.outstanding !== 9'd2) begin $display("FAIL ux_out2: got %0d want 2", ifa.outstanding); fails++; end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++; if (ifa.outstanding !== 9'd0 || ifa.req_valid !== 1'b0) begin $display("FAIL ux_rst: out %0d valid %b want 0/0", ifa.outstanding, ifa.req_valid); fails++; end
      ifa.cpl_valid = 1'b1; ifa.cpl_tag = 8'd1;
      step();
      ifa.cpl_valid = 1'b0;
      checks++; if (ifa.err_unexp_cpl !== 1'b1 || ifa.r_valid !== 4'b0) begin $display("FAIL ux_stale: err %b r_valid %b want 1/0000", ifa.err_unexp_cpl, ifa.r_valid); fails++; end
   endtask

   task automatic test_back_to_back;
      do_reset();
      ifa.s_valid[0] = 1'b1; ifa.s_type[1:0] = MRD; ifa.s_addr[31:0] = 32'h500; ifa.req_ready = 1'b1;
      step();
      step();
      step();
      step();
      checks++; if (ifa.outstanding !== 9'd2 || ifa.req_valid !== 1'b0) begin $display("FAIL bb_out2: out %0d valid %b want 2/0", ifa.outstanding, ifa.req_valid); fails++; end
      step();
      checks++; if (ifa.req_tag !== 8'd2 || ifa.s_ready !== 4'b0001) begin $display("FAIL bb_tag2: tag %h rdy %b want 02/0001", ifa.req_tag, ifa.s_ready); fails++; end
      ifa.cpl_valid = 1'b1; ifa.cpl_tag = 8'd1; ifa.cpl_data = 32'hCAFE0001; ifa.cpl_status = 3'b010;
      step();
      ifa.cpl_valid = 1'b0;
      checks++; if (ifa.outstanding !== 9'd2) begin $display("FAIL bb_same_edge: out %0d want 2", ifa.outstanding); fails++; end
      checks++; if (ifa.r_valid !== 4'b0001 || ifa.r_status !== 3'b010 || ifa.r_tag !== 8'd1 || ifa.r_data !== 32'hCAFE0001)
         begin $display("FAIL bb_route: r_valid %b st %0d tag %h data %h want 0001/2/01/cafe0001", ifa.r_valid, ifa.r_status, ifa.r_tag, ifa.r_data); fails++; end
      step();
      checks++; if (ifa.req_valid !== 1'b1 || ifa.req_tag !== 8'd1) begin $display("FAIL bb_reuse: valid %b tag %h want 1/01", ifa.req_valid, ifa.req_tag); fails++; end
      ifa.s_valid = '0;
      step();
      checks++; if (ifa.outstanding !== 9'd3) begin $display("FAIL bb_out3: got %0d want 3", ifa.outstanding); fails++; end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_inputs();
      test_reset();
      test_wait_states();
      test_round_robin();
      test_tag_exhaust();
      test_cpl_route();
      test_unexpected_and_reset();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
